// File: rtl/step_input_ctrl.sv
// -----------------------------------------------------------------------------
// step_input_ctrl
//   Conditions the raw board switches into clean synchronous controls for the
//   single-step MIPS core. Each switch is synchronised (two flops), debounced
//   (a level change must persist DEBOUNCE_CYCLES consecutive cycles) and, for
//   the step switch, rising-edge detected. A small IDLE/RUN/RST controller
//   turns these into a one-cycle core clock enable, a timed core reset, a
//   free-running run mode and a step counter.
//
// Ports
//   clk         in   board clock, everything on the rising edge
//   reset       in   synchronous active-high module reset
//   sw_step     in   raw step switch (asynchronous, bouncy)
//   sw_reset    in   raw core-reset switch (asynchronous, bouncy)
//   sw_run      in   raw run-mode switch (asynchronous, bouncy)
//   step_en     out  one-cycle pulse, core advances one instruction
//   cpu_reset   out  active-high reset to the core
//   run_active  out  high while the controller is in RUN
//   step_count  out  step_en pulses since the last core reset (wraps)
// -----------------------------------------------------------------------------
module step_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RUN_DIV         = 50000000,
    parameter int RST_HOLD        = 4,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sw_step,
    input  logic             sw_reset,
    input  logic             sw_run,
    output logic             step_en,
    output logic             cpu_reset,
    output logic             run_active,
    output logic [CNT_W-1:0] step_count
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DIV_W  = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam int HOLD_W = $clog2(RST_HOLD + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(RUN_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_DONE = HOLD_W'(RST_HOLD);

    // Bit positions of the three switches in the packed input vectors.
    localparam int IDX_STEP = 0;
    localparam int IDX_RST  = 1;
    localparam int IDX_RUN  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RST  = 2'd2
    } state_t;

    logic [2:0]       raw_s;
    logic [2:0]       sync1_r;
    logic [2:0]       sync2_r;
    logic [2:0]       db_r;
    logic [DB_W-1:0]  db_cnt_r [0:2];
    logic             step_prev_r;

    logic             rst_req_s;
    logic             run_db_s;
    logic             step_rise_s;

    state_t           state_r, state_s;
    logic [DIV_W-1:0] div_r, div_s;
    logic [HOLD_W-1:0] hold_r, hold_s;
    logic             step_en_s;
    logic             cpu_reset_s;
    logic             run_active_s;
    logic [CNT_W-1:0] count_s;

    assign raw_s = {sw_run, sw_reset, sw_step};

    // Two-flop synchroniser; the first stage feeds only the second stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Per-input debounce: count consecutive mismatching cycles, flip on the Nth.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                db_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] == db_r[i]) begin
                    db_cnt_r[i] <= '0;
                end else if (db_cnt_r[i] == DB_LAST) begin
                    db_r[i]     <= ~db_r[i];
                    db_cnt_r[i] <= '0;
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                end
            end
        end
    end

    // Previous debounced step level for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_prev_r <= 1'b0;
        end else begin
            step_prev_r <= db_r[IDX_STEP];
        end
    end

    assign rst_req_s   = db_r[IDX_RST];
    assign run_db_s    = db_r[IDX_RUN];
    assign step_rise_s = db_r[IDX_STEP] & ~step_prev_r;

    // Controller next-state and next-output logic; reset request outranks all.
    always_comb begin
        state_s     = state_r;
        div_s       = div_r;
        hold_s      = hold_r;
        step_en_s   = 1'b0;
        cpu_reset_s = 1'b0;
        count_s     = step_count;

        case (state_r)
            ST_IDLE: begin
                if (rst_req_s) begin
                    state_s     = ST_RST;
                    hold_s      = '0;
                    div_s       = '0;
                    cpu_reset_s = 1'b1;
                end else if (run_db_s) begin
                    state_s = ST_RUN;
                    div_s   = '0;
                end else if (step_rise_s) begin
                    step_en_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (rst_req_s) begin
                    state_s     = ST_RST;
                    hold_s      = '0;
                    div_s       = '0;
                    cpu_reset_s = 1'b1;
                end else if (!run_db_s) begin
                    // Leaving run mode suppresses any pulse due this cycle.
                    state_s = ST_IDLE;
                    div_s   = '0;
                end else if (div_r == DIV_LAST) begin
                    step_en_s = 1'b1;
                    div_s     = '0;
                end else begin
                    div_s = div_r + DIV_W'(1);
                end
            end
            ST_RST: begin
                div_s = '0;
                if (hold_r != HOLD_DONE) begin
                    hold_s = hold_r + HOLD_W'(1);
                end else begin
                    hold_s = hold_r;
                end
                // Core reset drops once the hold expires, even with the switch held.
                cpu_reset_s = (hold_s != HOLD_DONE);
                if ((hold_r == HOLD_DONE) && !rst_req_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RST;
                end
            end
            default: begin
                state_s     = ST_RST;
                hold_s      = '0;
                div_s       = '0;
                cpu_reset_s = 1'b1;
            end
        endcase

        if (state_s == ST_RST) begin
            count_s = '0;
        end else if (step_en_s) begin
            count_s = step_count + CNT_W'(1);
        end else begin
            count_s = step_count;
        end

        run_active_s = (state_s == ST_RUN);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_RST;
            div_r      <= '0;
            hold_r     <= '0;
            step_en    <= 1'b0;
            cpu_reset  <= 1'b1;
            run_active <= 1'b0;
            step_count <= '0;
        end else begin
            state_r    <= state_s;
            div_r      <= div_s;
            hold_r     <= hold_s;
            step_en    <= step_en_s;
            cpu_reset  <= cpu_reset_s;
            run_active <= run_active_s;
            step_count <= count_s;
        end
    end

endmodule
